// File: rtl/corr_result_formatter_if.sv
// Byte-stream and result-capture bundle for corr_result_formatter.
// The master side (formatter) consumes the engine result and drives the
// ASCII byte stream; the slave side is the engine/transmitter environment.
interface corr_result_formatter_if #(
  parameter int PROD_W = 22,
  parameter int LOC_W  = 11
);
  logic              done_in;
  logic [PROD_W-1:0] maxproduct_in;
  logic [LOC_W-1:0]  maxloc_in;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              msg_done;

  modport master (
    input  done_in, maxproduct_in, maxloc_in, tx_ready,
    output tx_data, tx_valid, busy, msg_done
  );

  modport slave (
    output done_in, maxproduct_in, maxloc_in, tx_ready,
    input  tx_data, tx_valid, busy, msg_done
  );
endinterface

// File: rtl/corr_result_formatter.sv
// corr_result_formatter: captures the correlation engine's max product and
// location on the rising edge of done_in, then streams a fixed ASCII report
// ("Max value <hex>\r\nMax location <hex>\r\n") one byte per valid/ready
// handshake. Engine activity is ignored until the message has completed.
//
// Build option: define RESULT_FMT_SIGNMAG_EN to print the product as a
// sign character followed by the hex magnitude instead of two's complement.
module corr_result_formatter #(
  parameter int PROD_W   = 22,
  parameter int LOC_W    = 11,
  parameter int PROD_DIG = (PROD_W + 3) / 4,
  parameter int LOC_DIG  = (LOC_W + 3) / 4
) (
  input logic                   clk,
  input logic                   rst,
  corr_result_formatter_if.master bus
);

  // Message layout (byte offsets)
  localparam int TXT_VAL_LEN = 10;
  localparam int TXT_LOC_LEN = 13;
  localparam logic [8*TXT_VAL_LEN-1:0] TXT_VAL = "Max value ";
  localparam logic [8*TXT_LOC_LEN-1:0] TXT_LOC = "Max location ";
`ifdef RESULT_FMT_SIGNMAG_EN
  localparam int SGN_W = 1;
`else
  localparam int SGN_W = 0;
`endif
  localparam int O_PDIG = TXT_VAL_LEN + SGN_W;
  localparam int O_CR1  = O_PDIG + PROD_DIG;
  localparam int O_LTXT = O_CR1 + 2;
  localparam int O_LDIG = O_LTXT + TXT_LOC_LEN;
  localparam int O_CR2  = O_LDIG + LOC_DIG;
  localparam int N      = O_CR2 + 2;
  localparam int IDX_W  = $clog2(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  localparam int PW = 4 * PROD_DIG;
  localparam int LW = 4 * LOC_DIG;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    EMIT    = 2'd2,
    FIN     = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             done_q_r;
  logic [IDX_W-1:0] idx_r;
  logic [PW-1:0]    prod_r;
  logic [LW-1:0]    loc_r;
`ifdef RESULT_FMT_SIGNMAG_EN
  logic             neg_r;
`endif

  logic             start_s;
  logic             last_acc_s;
  logic [PW-1:0]    prod_ext_s;
  logic [LW-1:0]    loc_ext_s;
  logic [7:0]       tx_data_s;
  logic             tx_valid_s;
  logic             busy_s;
  logic             msg_done_s;

  // Uppercase ASCII for one hex nibble
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) c = 8'h30 + {4'h0, n};
    else           c = 8'h37 + {4'h0, n};
    return c;
  endfunction

  // Character at message position idx, built from the frozen operands
  function automatic logic [7:0] char_at(input int idx);
    logic [7:0] c;
    int         k;
    c = 8'h00;
    k = 0;
    if (idx < TXT_VAL_LEN) begin
      c = TXT_VAL[8*(TXT_VAL_LEN-1-idx) +: 8];
`ifdef RESULT_FMT_SIGNMAG_EN
    end else if (idx < O_PDIG) begin
      c = neg_r ? 8'h2D : 8'h2B;
`endif
    end else if (idx < O_CR1) begin
      k = idx - O_PDIG;
      c = hex_char(prod_r[4*(PROD_DIG-1-k) +: 4]);
    end else if (idx == O_CR1) begin
      c = 8'h0D;
    end else if (idx == O_CR1 + 1) begin
      c = 8'h0A;
    end else if (idx < O_LDIG) begin
      c = TXT_LOC[8*(O_LDIG-1-idx) +: 8];
    end else if (idx < O_CR2) begin
      k = idx - O_LDIG;
      c = hex_char(loc_r[4*(LOC_DIG-1-k) +: 4]);
    end else if (idx == O_CR2) begin
      c = 8'h0D;
    end else if (idx == O_CR2 + 1) begin
      c = 8'h0A;
    end else begin
      c = 8'h00;
    end
    return c;
  endfunction

  // Trigger, operand extension and end-of-message detection
  always_comb begin
    start_s    = bus.done_in & ~done_q_r & (state_r == IDLE);
    last_acc_s = (state_r == EMIT) & bus.tx_ready & (idx_r == LAST);
    prod_ext_s = PW'($signed(bus.maxproduct_in));
    loc_ext_s  = LW'(bus.maxloc_in);
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_s = CAPTURE;
        else         state_s = IDLE;
      end
      CAPTURE: state_s = EMIT;
      EMIT: begin
        if (last_acc_s) state_s = FIN;
        else            state_s = EMIT;
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Edge detector, byte index and frozen operands
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q_r <= 1'b0;
      idx_r    <= '0;
      prod_r   <= '0;
      loc_r    <= '0;
`ifdef RESULT_FMT_SIGNMAG_EN
      neg_r    <= 1'b0;
`endif
    end else begin
      done_q_r <= bus.done_in;
      if (state_r == CAPTURE) begin
        idx_r <= '0;
        loc_r <= loc_ext_s;
`ifdef RESULT_FMT_SIGNMAG_EN
        // Magnitude fits PW bits: the most negative value yields 2^(PROD_W-1)
        neg_r  <= prod_ext_s[PW-1];
        prod_r <= prod_ext_s[PW-1] ? (~prod_ext_s + PW'(1)) : prod_ext_s;
`else
        prod_r <= prod_ext_s;
`endif
      end else if ((state_r == EMIT) && bus.tx_ready && (idx_r != LAST)) begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end
  end

  // Stream outputs decoded from registered state only (no tx_ready path)
  always_comb begin
    tx_valid_s = 1'b0;
    tx_data_s  = 8'h00;
    busy_s     = 1'b0;
    msg_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
      end
      CAPTURE: begin
        busy_s = 1'b1;
      end
      EMIT: begin
        busy_s     = 1'b1;
        tx_valid_s = 1'b1;
        tx_data_s  = char_at(int'(idx_r));
      end
      FIN: begin
        msg_done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign bus.tx_valid = tx_valid_s;
  assign bus.tx_data  = tx_data_s;
  assign bus.busy     = busy_s;
  assign bus.msg_done = msg_done_s;

endmodule

// File: tb/tb_corr_result_formatter.sv
// Directed self-checking bench for corr_result_formatter.
module tb_corr_result_formatter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  corr_result_formatter_if #(.PROD_W(22), .LOC_W(11)) bus ();

  corr_result_formatter #(.PROD_W(22), .LOC_W(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef RESULT_FMT_SIGNMAG_EN
  localparam int         N_EXP  = 37;
  localparam logic [7:0] BYTE15 = 8'h44;
  localparam string S_1234 = "Max value +0004D2\015\012Max location 3BF\015\012";
  localparam string S_NEG1 = "Max value -000001\015\012Max location 000\015\012";
  localparam string S_MIN  = "Max value -200000\015\012Max location 7FF\015\012";
  localparam string S_MAX  = "Max value +1FFFFF\015\012Max location 001\015\012";
  localparam string S_NEW  = "Max value +0ABCDE\015\012Max location 123\015\012";
`else
  localparam int         N_EXP  = 36;
  localparam logic [7:0] BYTE15 = 8'h32;
  localparam string S_1234 = "Max value 0004D2\015\012Max location 3BF\015\012";
  localparam string S_NEG1 = "Max value FFFFFF\015\012Max location 000\015\012";
  localparam string S_MIN  = "Max value E00000\015\012Max location 7FF\015\012";
  localparam string S_MAX  = "Max value 1FFFFF\015\012Max location 001\015\012";
  localparam string S_NEW  = "Max value 0ABCDE\015\012Max location 123\015\012";
`endif

  byte unsigned got[$];
  int           n_pulse;
  int           span;
  int           unstable;
  bit           timed_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string got_str();
    string s;
    s = "";
    foreach (got[i]) s = $sformatf("%s%c", s, got[i]);
    return s;
  endfunction

  function automatic string printable(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D || s[i] == 8'h0A) r = {r, "~"};
      else r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  // Produce a fresh rising edge on done_in with new operands
  task automatic arm(input logic [21:0] p, input logic [10:0] l);
    @(negedge clk);
    bus.done_in = 1'b0;
    repeat (2) @(negedge clk);
    bus.maxproduct_in = p;
    bus.maxloc_in     = l;
    bus.done_in       = 1'b1;
  endtask

  // Run the byte sink until msg_done plus a few idle cycles (bounded)
  task automatic collect(input int duty, input bit perturb);
    bit         prev_hold;
    logic [7:0] held;
    int         first;
    int         last;
    int         post;
    got.delete();
    n_pulse = 0; unstable = 0; span = 0; timed_out = 1'b1;
    prev_hold = 1'b0; held = 8'h00; first = -1; last = -1; post = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (perturb) begin
        if (cyc == 8) bus.done_in = 1'b0;
        if (cyc == 10) begin
          bus.maxproduct_in = 22'h0ABCDE;
          bus.maxloc_in     = 11'h123;
          bus.done_in       = 1'b1;
        end
        if (cyc == 12) bus.done_in = 1'b0;
        if (cyc == 14) bus.done_in = 1'b1;
      end
      if (duty >= 100) bus.tx_ready = 1'b1;
      else bus.tx_ready = ($urandom_range(0, 99) < duty) ? 1'b1 : 1'b0;
      if (prev_hold && (bus.tx_valid !== 1'b1 || bus.tx_data !== held)) unstable++;
      if (bus.msg_done === 1'b1) n_pulse++;
      if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
        got.push_back(bus.tx_data);
        if (first < 0) first = cyc;
        last = cyc;
      end
      prev_hold = (bus.tx_valid === 1'b1) && (bus.tx_ready !== 1'b1);
      held = bus.tx_data;
      if (post < 0 && n_pulse > 0) post = 4;
      if (post == 0) begin
        timed_out = 1'b0;
        break;
      end
      if (post > 0) post--;
    end
    bus.tx_ready = 1'b0;
    span = (first >= 0) ? (last - first + 1) : 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.done_in = 1'b1;
    bus.maxproduct_in = 22'd1234;
    bus.maxloc_in = 11'd959;
    bus.tx_ready = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.tx_valid); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++;
    if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus.tx_data); end
    total++;
    if (bus.msg_done !== 1'b0) begin bad++; $display("FAIL reset_msg_done got=%b exp=0", bus.msg_done); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL latency_early got=%b exp=0", bus.tx_valid); end
    @(negedge clk);
    total++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h4D) begin
      bad++; $display("FAIL latency_first valid=%b data=%h exp valid=1 data=4d", bus.tx_valid, bus.tx_data);
    end
    collect(100, 1'b0);
    total++;
    if (timed_out !== 1'b0 || got_str() != S_1234) begin
      bad++; $display("FAIL reset_msg got='%s' exp='%s'", printable(got_str()), printable(S_1234));
    end
  endtask

  task automatic test_back_to_back();
    arm(22'd1234, 11'd959);
    collect(100, 1'b0);
    total++;
    if (timed_out !== 1'b0) begin bad++; $display("FAIL b2b_timeout got=1 exp=0"); end
    total++;
    if (got_str() != S_1234) begin
      bad++; $display("FAIL b2b_msg got='%s' exp='%s'", printable(got_str()), printable(S_1234));
    end
    total++;
    if (span !== N_EXP) begin bad++; $display("FAIL b2b_span got=%0d exp=%0d", span, N_EXP); end
    total++;
    if (n_pulse !== 1) begin bad++; $display("FAIL b2b_pulses got=%0d exp=1", n_pulse); end
    total++;
    if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_idle busy=%b valid=%b exp 0 0", bus.busy, bus.tx_valid);
    end
  endtask

  task automatic test_values();
    arm(22'h3FFFFF, 11'd0);
    collect(100, 1'b0);
    total++;
    if (timed_out !== 1'b0 || got_str() != S_NEG1) begin
      bad++; $display("FAIL neg1_msg got='%s' exp='%s'", printable(got_str()), printable(S_NEG1));
    end
    arm(22'h200000, 11'h7FF);
    collect(100, 1'b0);
    total++;
    if (timed_out !== 1'b0 || got_str() != S_MIN) begin
      bad++; $display("FAIL min_msg got='%s' exp='%s'", printable(got_str()), printable(S_MIN));
    end
    arm(22'h1FFFFF, 11'h001);
    collect(100, 1'b0);
    total++;
    if (timed_out !== 1'b0 || got_str() != S_MAX) begin
      bad++; $display("FAIL max_msg got='%s' exp='%s'", printable(got_str()), printable(S_MAX));
    end
  endtask

  task automatic test_backpressure();
    arm(22'd1234, 11'd959);
    collect(30, 1'b0);
    total++;
    if (timed_out !== 1'b0 || got_str() != S_1234) begin
      bad++; $display("FAIL bp_msg got='%s' exp='%s'", printable(got_str()), printable(S_1234));
    end
    total++;
    if (unstable !== 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
    total++;
    if (n_pulse !== 1) begin bad++; $display("FAIL bp_pulses got=%0d exp=1", n_pulse); end
  endtask

  task automatic test_ignore_inputs();
    int stray;
    arm(22'd1234, 11'd959);
    collect(100, 1'b1);
    total++;
    if (timed_out !== 1'b0 || got_str() != S_1234) begin
      bad++; $display("FAIL frozen_msg got='%s' exp='%s'", printable(got_str()), printable(S_1234));
    end
    total++;
    if (n_pulse !== 1) begin bad++; $display("FAIL frozen_pulses got=%0d exp=1", n_pulse); end
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) stray++;
    end
    total++;
    if (stray !== 0) begin bad++; $display("FAIL no_queue got=%0d active cycles exp=0", stray); end
    arm(22'h0ABCDE, 11'h123);
    collect(100, 1'b0);
    total++;
    if (timed_out !== 1'b0 || got_str() != S_NEW) begin
      bad++; $display("FAIL new_msg got='%s' exp='%s'", printable(got_str()), printable(S_NEW));
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    bit reached;
    arm(22'd1234, 11'd959);
    bus.tx_ready = 1'b1;
    acc = 0;
    reached = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (acc == 15) begin
        reached = 1'b1;
        break;
      end
      if (bus.tx_valid === 1'b1) acc++;
    end
    total++;
    if (reached !== 1'b1 || bus.tx_data !== BYTE15 || bus.tx_valid !== 1'b1) begin
      bad++; $display("FAIL mid_byte15 data=%h valid=%b exp data=%h valid=1", bus.tx_data, bus.tx_valid, BYTE15);
    end
    rst = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    total++;
    if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL mid_abort valid=%b busy=%b exp 0 0", bus.tx_valid, bus.busy);
    end
    rst = 1'b0;
    collect(100, 1'b0);
    total++;
    if (timed_out !== 1'b0 || got_str() != S_1234) begin
      bad++; $display("FAIL mid_restart got='%s' exp='%s'", printable(got_str()), printable(S_1234));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.done_in       = 1'b0;
    bus.maxproduct_in = 22'd0;
    bus.maxloc_in     = 11'd0;
    bus.tx_ready      = 1'b0;
    test_reset();
    test_back_to_back();
    test_values();
    test_backpressure();
    test_ignore_inputs();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/corr_result_formatter.md
Name: corr_result_formatter

Overview:
Downstream stage of the correlation engine. Captures the final maximum correlation product and its shift location when the engine's done level rises. Renders both as fixed-format ASCII hex text and streams the bytes one at a time over a valid/ready byte interface to the UART transmitter. Holds results stable for the whole message. Ignores the engine until the message completes.

Parameters:
PROD_W, 22, width of signed max-product input
LOC_W, 11, width of unsigned max-location input
PROD_DIG, 6, hex digits printed for product, ceil(PROD_W/4); product is sign-extended to 4*PROD_DIG bits
LOC_DIG, 3, hex digits printed for location, ceil(LOC_W/4); location is zero-extended

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
done_in  input  1  correlation engine done level; stays high once set
maxproduct_in  input  PROD_W  signed max product, valid while done_in high
maxloc_in  input  LOC_W  unsigned location of max product
tx_data  output  8  ASCII byte to transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  transmitter accepts byte this cycle
busy  output  1  high from capture to last byte accepted
msg_done  output  1  one-cycle pulse after last byte accepted

Behaviour:
- Reset: synchronous; rst=1 at a clock edge forces state IDLE, byte index 0, captured registers 0, done_in edge register 0, tx_valid=0, tx_data=8'h00, busy=0, msg_done=0. Reset mid-message aborts immediately. No partial byte completes after reset.
- Trigger: done_q holds done_in registered. start = done_in & ~done_q & (state==IDLE). A high done_in held through reset counts as a new rising edge after reset. Rising edges while not IDLE are ignored and never queued.
- Message, fixed order, bytes indexed 0..N-1:
  - "Max value "
  - PROD_DIG hex digits, MSB first
  - CR LF
  - "Max location "
  - LOC_DIG hex digits
  - CR LF
- With default parameters N = 10+6+2+13+3+2 = 36.
- Hex digits are uppercase ASCII: 0-9 map to 8'h30-8'h39, A-F map to 8'h41-8'h46.
- FSM states:
  - IDLE: on start, go to CAPTURE.
  - CAPTURE (1 cycle): latch maxproduct_in and maxloc_in, set busy=1, clear index, go to EMIT.
  - EMIT: drive tx_data = char(index) from registered operands, tx_valid=1.
    - On tx_valid & tx_ready: if index==N-1 go to FIN, else index+1 and stay in EMIT.
  - FIN (1 cycle): tx_valid=0, busy=0, msg_done=1, go to IDLE.
- Latency: first byte appears with tx_valid=1 two cycles after the cycle done_in is first sampled high.
- Handshake rules:
  - tx_valid never drops and tx_data never changes while tx_valid & ~tx_ready.
  - Back-to-back transfers allowed: tx_ready held high gives one byte per cycle, so 36 consecutive cycles.
  - Output is combinational from registered index/operands only; no combinational path from tx_ready to tx_data.
- Operands are frozen from CAPTURE to FIN. Input changes during a message have no effect.
- Negative product: printed as two's complement of the sign-extended value, e.g. -1 prints FFFFFF.

Optional Feature:
- Macro RESULT_FMT_SIGNMAG_EN.
- Defined: the product field becomes a sign character ('+' 8'h2B or '-' 8'h2D) followed by PROD_DIG hex digits of |product|.
  - Magnitude is computed in CAPTURE into a 4*PROD_DIG-bit register.
  - N = 37.
  - The most negative value -2^(PROD_W-1) prints as "-200000".
- Undefined: two's-complement hex as above, N = 36, no sign character.

Test Plan:
- rst high, done_in high -> tx_valid=0, busy=0 throughout reset. After rst drops, message starts: first byte 'M' (8'h4D) with tx_valid=1 two cycles after first non-reset edge.
- maxproduct_in=1234, maxloc_in=959, tx_ready=1 -> 36 bytes "Max value 0004D2\r\nMax location 3BF\r\n" on consecutive cycles. msg_done pulses once, busy low after.
- maxproduct_in=-1, maxloc_in=0 -> "Max value FFFFFF ... Max location 000". With RESULT_FMT_SIGNMAG_EN: "Max value -000001", 37 bytes.
- tx_ready random ~30% duty -> each byte stable until accepted, no byte skipped or duplicated, stream identical to test 2.
- Change maxproduct_in/maxloc_in and toggle done_in mid-message -> output unchanged, no second message. New rising edge after FIN -> one new message with new values.
- Assert rst at byte index 15 -> tx_valid=0, busy=0 next cycle. With done_in still high, a complete fresh message restarts from 'M'.
